// File: rtl/complex_butterfly_stage_32b.sv
// Radix-2 complex butterfly (X = A+B, Y = A-B) with optional /2 scaling, rounding
// and saturation, in a 2-stage valid/ready pipeline with a sticky overflow flag.
module complex_butterfly_stage_32b #(
  parameter int SCALE = 1,
  parameter int ROUND = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_x,
  output logic [31:0] out_y,
  output logic        ovf_flag,
  input  logic        ovf_clr
);

  logic        s1_valid;
  logic        s2_valid;
  logic        s1_adv;
  logic        s2_adv;
  logic        accept;
  logic        sat;

  logic [16:0] a_re, a_im, b_re, b_im;
  logic [16:0] s1_sr, s1_si, s1_dr, s1_di;
  logic [16:0] px_r, px_i, py_r, py_i;

  // Result is {clipped, value[15:0]}; the 18-bit intermediate keeps t+ROUND exact.
  function automatic logic [16:0] post(input logic [16:0] t);
    logic signed [17:0] v;
    logic [16:0]        r;
    v = $signed({t[16], t});
    if (SCALE != 0) begin
      if (ROUND != 0) v = v + 18'sd1;
      v = v >>> 1;
    end
    if (v > 18'sd32767)       r = {1'b1, 16'h7fff};
    else if (v < -18'sd32768) r = {1'b1, 16'h8000};
    else                      r = {1'b0, v[15:0]};
    return r;
  endfunction

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign accept    = in_valid && s1_adv;
  assign out_valid = s2_valid;

  assign a_re = {in_a[31], in_a[31:16]};
  assign a_im = {in_a[15], in_a[15:0]};
  assign b_re = {in_b[31], in_b[31:16]};
  assign b_im = {in_b[15], in_b[15:0]};

  always_comb begin
    px_r = post(s1_sr);
    px_i = post(s1_si);
    py_r = post(s1_dr);
    py_i = post(s1_di);
    sat  = s2_adv && s1_valid && (px_r[16] || px_i[16] || py_r[16] || py_i[16]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      out_x    <= '0;
      out_y    <= '0;
      ovf_flag <= 1'b0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_sr    <= a_re + b_re;
        s1_si    <= a_im + b_im;
        s1_dr    <= a_re - b_re;
        s1_di    <= a_im - b_im;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      // Output registers only change when a valid word moves in, so they hold while stalled.
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_x <= {px_r[15:0], px_i[15:0]};
          out_y <= {py_r[15:0], py_i[15:0]};
        end
      end
      ovf_flag <= (ovf_flag && !ovf_clr) || sat;
    end
  end

endmodule

// File: tb/tb_complex_butterfly_stage_32b.sv
// Scoreboard bench: dut[0] has SCALE=0, dut[1] has SCALE=1/ROUND=1; expectations are
// queued on accept and popped by per-DUT monitors on each output transfer.
module tb_complex_butterfly_stage_32b;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] in_a      [2];
  logic [31:0] in_b      [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [31:0] out_x     [2];
  logic [31:0] out_y     [2];
  logic        ovf_flag  [2];
  logic        ovf_clr   [2];

  logic [63:0] exp_q [2][$];
  int total = 0;
  int bad   = 0;
  bit done_rand;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    complex_butterfly_stage_32b #(.SCALE(g), .ROUND(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_a(in_a[g]), .in_b(in_b[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]),
      .out_x(out_x[g]), .out_y(out_y[g]),
      .ovf_flag(ovf_flag[g]), .ovf_clr(ovf_clr[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: bound expired", name);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_mon
    bit          stalled = 1'b0;
    logic [63:0] held;
    always @(negedge clk) begin
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          chk($sformatf("hold_valid%0d", g), 64'(out_valid[g]), 64'd1);
          chk($sformatf("hold_data%0d", g), {out_x[g], out_y[g]}, held);
        end
        if (out_valid[g] && out_ready[g]) begin
          if (exp_q[g].size() == 0) fail_now($sformatf("extra_output%0d", g));
          else chk($sformatf("data%0d", g), {out_x[g], out_y[g]}, exp_q[g].pop_front());
        end
        stalled = out_valid[g] && !out_ready[g];
        held    = {out_x[g], out_y[g]};
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input int g, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ex, input logic [31:0] ey);
    int n = 0;
    in_valid[g] = 1'b1;
    in_a[g]     = a;
    in_b[g]     = b;
    @(negedge clk);
    while (!in_ready[g] && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[g]) fail_now("accept_timeout");
    else exp_q[g].push_back({ex, ey});
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if ((exp_q[0].size() + exp_q[1].size()) != 0) fail_now("drain");
  endtask

  task automatic check_latency(input int g);
    chk("lat_cycle1", 64'(out_valid[g]), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_cycle2", 64'(out_valid[g]), 64'd1);
  endtask

  function automatic logic [15:0] ref_comp(input int scale, input int t);
    int v;
    v = t;
    if (scale != 0) v = (t + 1 >= 0) ? (t + 1) / 2 : -((-(t + 1) + 1) / 2);
    if (v > 32767)  v = 32767;
    if (v < -32768) v = -32768;
    return 16'(v);
  endfunction

  function automatic logic [31:0] ref_word(input int scale, input logic [31:0] a,
                                           input logic [31:0] b, input bit sub);
    int ar, ai, br, bi;
    ar = int'($signed(a[31:16]));
    ai = int'($signed(a[15:0]));
    br = int'($signed(b[31:16]));
    bi = int'($signed(b[15:0]));
    if (sub) return {ref_comp(scale, ar - br), ref_comp(scale, ai - bi)};
    return {ref_comp(scale, ar + br), ref_comp(scale, ai + bi)};
  endfunction

  task automatic rand_driver(input int g, input int words);
    logic [31:0] a, b;
    for (int i = 0; i < words; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      a = $urandom;
      b = $urandom;
      if (i % 16 == 0) a = 32'h7fff_8000;
      send(g, a, b, ref_word(g, a, b, 1'b0), ref_word(g, a, b, 1'b1));
    end
  endtask

  initial begin
    bit saw_full;
    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; in_a[g] = '0; in_b[g] = '0;
      out_ready[g] = 1'b1; ovf_clr[g] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_out_valid", 64'(out_valid[g]), 64'd0);
      chk("rst_in_ready", 64'(in_ready[g]), 64'd1);
      chk("rst_ovf", 64'(ovf_flag[g]), 64'd0);
      chk("rst_out_x", 64'(out_x[g]), 64'd0);
      chk("rst_out_y", 64'(out_y[g]), 64'd0);
    end
    @(posedge clk);
    #1;

    // SCALE=0 basic add/sub with 2-cycle latency
    send(0, 32'h0003_0005, 32'h0001_ffff, 32'h0004_0004, 32'h0002_0006);
    check_latency(0);
    wait_empty();
    chk("ovf_clean", 64'(ovf_flag[0]), 64'd0);

    // SCALE=0 positive saturation, then clear
    @(posedge clk); #1;
    send(0, 32'h7fff_0000, 32'h0001_0000, 32'h7fff_0000, 32'h7ffe_0000);
    wait_empty();
    chk("ovf_set", 64'(ovf_flag[0]), 64'd1);
    ovf_clr[0] = 1'b1;
    @(posedge clk); #1;
    ovf_clr[0] = 1'b0;
    chk("ovf_cleared", 64'(ovf_flag[0]), 64'd0);

    // Negative saturation while ovf_clr held: set wins on the load edge
    ovf_clr[0] = 1'b1;
    send(0, 32'h8000_0000, 32'h0001_0000, 32'h8001_0000, 32'h8000_0000);
    @(posedge clk); #1;
    chk("set_wins_valid", 64'(out_valid[0]), 64'd1);
    chk("set_wins_ovf", 64'(ovf_flag[0]), 64'd1);
    ovf_clr[0] = 1'b0;
    wait_empty();

    // SCALE=1 ROUND=1 vectors
    @(posedge clk); #1;
    send(1, 32'h7fff_8000, 32'h8000_8000, 32'h0000_8000, 32'h7fff_0000);
    send(1, 32'h0003_0001, 32'h0000_0000, 32'h0002_0001, 32'h0002_0001);
    send(1, 32'hfffd_ffff, 32'h0000_0000, 32'hffff_0000, 32'hffff_0000);
    send(1, 32'h0005_0002, 32'h0002_0001, 32'h0004_0002, 32'h0002_0001);
    wait_empty();
    chk("ovf_scaled", 64'(ovf_flag[1]), 64'd1);

    // Backpressure: 8 words streaming, out_ready low for cycles 3-7
    @(posedge clk); #1;
    saw_full = 1'b0;
    fork
      for (int i = 0; i < 8; i++)
        send(0, {16'(i), 16'(2 * i)}, {16'd1, 16'hffff},
             {16'(i + 1), 16'(2 * i - 1)}, {16'(i - 1), 16'(2 * i + 1)});
      for (int c = 0; c < 16; c++) begin
        out_ready[0] = !(c >= 3 && c <= 7);
        @(negedge clk);
        if (!in_ready[0]) saw_full = 1'b1;
        @(posedge clk); #1;
      end
    join
    out_ready[0] = 1'b1;
    wait_empty();
    chk("bp_in_ready_dropped", 64'(saw_full), 64'd1);

    // Reset with both stages holding valid words
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    send(0, 32'h7fff_0000, 32'h0001_0000, 32'h7fff_0000, 32'h7ffe_0000);
    send(0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0002, 32'h0000_0000);
    chk("pre_rst_valid", 64'(out_valid[0]), 64'd1);
    chk("pre_rst_ovf", 64'(ovf_flag[0]), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q[0].delete();
    exp_q[1].delete();
    chk("post_rst_valid", 64'(out_valid[0]), 64'd0);
    chk("post_rst_ovf", 64'(ovf_flag[0]), 64'd0);
    chk("post_rst_in_ready", 64'(in_ready[0]), 64'd1);
    out_ready[0] = 1'b1;
    send(0, 32'h0010_0020, 32'h0001_0002, 32'h0011_0022, 32'h000f_001e);
    check_latency(0);
    wait_empty();

    // Random traffic on both DUTs against the reference model
    @(posedge clk); #1;
    done_rand = 1'b0;
    fork
      begin
        fork
          rand_driver(0, 300);
          rand_driver(1, 300);
        join
        done_rand = 1'b1;
      end
      for (int c = 0; c < 20000 && !done_rand; c++) begin
        out_ready[0] = 1'($urandom_range(0, 1));
        out_ready[1] = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    join
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
